// File: rtl/key_display_pkg.sv
// key_display_pkg: shared types and constants for the key display scheduler.
//   sched_state_t  : scheduler FSM states (IDLE, SHOW)
//   PS2_BREAK_CODE : PS/2 break prefix byte (0xF0)
//   PS2_EXT_CODE   : PS/2 extended prefix byte (0xE0), queued like any other byte
package key_display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } sched_state_t;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

endpackage

// File: rtl/key_fifo.sv
// key_fifo: small synchronous FIFO for scan-code bytes.
//   clk, reset : clock, asynchronous active-high reset (clears pointers/count)
//   push, din  : write request and data; accepted when not full, or when full
//                and a pop happens in the same cycle (the pop frees the slot)
//   pop, dout  : read request; dout is the current head (valid when !empty)
//   count      : entries currently stored
//   full/empty : occupancy flags
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_display_sched.sv
// key_display_sched: queues PS/2 scan-code bytes and presents each one to the
// display path for a minimum dwell time.
//   clk, reset   : clock, asynchronous active-high reset
//   key_ready    : one-cycle pulse, key valid in the same cycle
//   key          : received scan-code byte
//   clr_overflow : synchronous clear of the sticky overflow flag
//   disp_value   : byte shown on the display (held after the dwell ends)
//   disp_strobe  : one-cycle pulse whenever disp_value is loaded
//   busy         : high while a dwell period runs
//   fifo_count   : entries queued
//   overflow     : sticky, a byte was dropped because the FIFO was full
// Build option: define KEY_DISPLAY_SCHED_BREAK_FILTER_EN to drop PS/2 break
// sequences (0xF0 and the byte following it) so only make codes are shown.
module key_display_sched
    import key_display_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int DWELL_CYCLES = 50000000,
    parameter int DWELL_W      = 26
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         key_ready,
    input  logic [7:0]                   key,
    input  logic                         clr_overflow,
    output logic [7:0]                   disp_value,
    output logic                         disp_strobe,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow
);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    sched_state_t       state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               accept;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [7:0]         fifo_dout;

`ifdef KEY_DISPLAY_SCHED_BREAK_FILTER_EN
    logic break_pending;

    // 0xF0 and the byte after it are swallowed; 0xE0 passes like a make code.
    assign accept = key_ready && !break_pending && (key != PS2_BREAK_CODE);

    // Every received byte either (re)arms the filter (0xF0) or consumes it,
    // so the next state is simply "this byte was a break prefix".
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            break_pending <= 1'b0;
        else if (key_ready)
            break_pending <= (key == PS2_BREAK_CODE);
    end
`else
    assign accept = key_ready;
`endif

    // Pop whenever the display can take a new byte: idle, or at the last
    // dwell cycle (back-to-back hand-off with no idle gap).
    assign pop  = !fifo_empty &&
                  ((state == IDLE) || (state == SHOW && dwell_cnt == DWELL_LAST));
    // A same-cycle pop frees the slot, so a push to a full FIFO survives.
    assign drop = accept && fifo_full && !pop;

    key_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (key),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dwell_cnt   <= '0;
            disp_value  <= '0;
            disp_strobe <= 1'b0;
            busy        <= 1'b0;
        end else begin
            disp_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        disp_value  <= fifo_dout;
                        disp_strobe <= 1'b1;
                        dwell_cnt   <= '0;
                        busy        <= 1'b1;
                        state       <= SHOW;
                    end
                end
                SHOW: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        if (!fifo_empty) begin
                            disp_value  <= fifo_dout;
                            disp_strobe <= 1'b1;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Set-dominant: a drop in the clearing cycle keeps the flag raised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clr_overflow)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_key_display_sched.sv
// Directed bench for key_display_sched with DEPTH=4, DWELL_CYCLES=4.
module tb_key_display_sched;

    logic       clk;
    logic       reset;
    logic       key_ready;
    logic [7:0] key;
    logic       clr_overflow;
    logic [7:0] disp_value;
    logic       disp_strobe;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int peak  = 0;
    logic [7:0] shown[$];
    int         shown_cyc[$];
    logic [7:0] exp_q[$];

    key_display_sched #(
        .DEPTH        (4),
        .DWELL_CYCLES (4),
        .DWELL_W      (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_ready    (key_ready),
        .key          (key),
        .clr_overflow (clr_overflow),
        .disp_value   (disp_value),
        .disp_strobe  (disp_strobe),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log every displayed byte with the cycle it appeared in.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (disp_strobe) begin
            shown.push_back(disp_value);
            shown_cyc.push_back(cyc);
        end
        if (int'(fifo_count) > peak)
            peak = int'(fifo_count);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        key_ready = 1'b1;
        key       = b;
        tick();
        key_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || fifo_count != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200)
            check("wait_idle_timeout", 32'd1, 32'd0);
        tick();
    endtask

    task automatic clear_log();
        shown.delete();
        shown_cyc.delete();
        peak = 0;
    endtask

    task automatic verify_shown(input string tag);
        check({tag, "_n"}, shown.size(), exp_q.size());
        for (int i = 0; i < shown.size() && i < exp_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), shown[i], exp_q[i]);
    endtask

    initial begin
        reset = 1'b1;
        key_ready = 1'b0;
        key = 8'h00;
        clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_value", disp_value, 8'h00);
        check("rst_strobe", disp_strobe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_ovf", overflow, 1'b0);
        reset = 1'b0;
        tick();

        // 1: single byte, latency and dwell length.
        clear_log();
        send(8'h1C);
        check("t1_push_strobe", disp_strobe, 1'b0);
        check("t1_push_count", fifo_count, 3'd1);
        tick();
        check("t1_strobe", disp_strobe, 1'b1);
        check("t1_value", disp_value, 8'h1C);
        check("t1_busy0", busy, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("t1_busy%0d", i), busy, 1'b1);
            check($sformatf("t1_nostrobe%0d", i), disp_strobe, 1'b0);
        end
        tick();
        check("t1_busy_end", busy, 1'b0);
        repeat (3) tick();
        check("t1_hold", disp_value, 8'h1C);

        // 2: burst of three, strobes exactly 4 cycles apart.
        clear_log();
        send(8'h1C); send(8'h32); send(8'h21);
        wait_idle();
        exp_q = '{8'h1C, 8'h32, 8'h21};
        verify_shown("t2");
        if (shown_cyc.size() == 3) begin
            check("t2_gap1", shown_cyc[1] - shown_cyc[0], 4);
            check("t2_gap2", shown_cyc[2] - shown_cyc[1], 4);
        end
        check("t2_peak", peak, 2);

        // 3: six bytes during a dwell, exactly one dropped.
        clear_log();
        send(8'hAA);
        tick();
        for (int i = 1; i <= 6; i++)
            send(8'(i));
        check("t3_ovf_set", overflow, 1'b1);
        wait_idle();
        exp_q = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        verify_shown("t3");
        check("t3_ovf_sticky", overflow, 1'b1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t3_ovf_clr", overflow, 1'b0);

        // 4: break sequence.
        clear_log();
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'h32);
        wait_idle();
`ifdef KEY_DISPLAY_SCHED_BREAK_FILTER_EN
        exp_q = '{8'h1C, 8'h32};
`else
        exp_q = '{8'h1C, 8'hF0, 8'h1C, 8'h32};
`endif
        verify_shown("t4");
        check("t4_ovf", overflow, 1'b0);

        // 5: asynchronous reset mid-dwell with two entries queued.
        send(8'h11); send(8'h22); send(8'h33);
        tick();
        check("t5_pre_count", fifo_count, 3'd2);
        #2;
        reset = 1'b1;
        #1;
        check("t5_value", disp_value, 8'h00);
        check("t5_strobe", disp_strobe, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_count", fifo_count, 3'd0);
        check("t5_ovf", overflow, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_log();
        repeat (10) tick();
        check("t5_no_strobe", shown.size(), 0);
        check("t5_idle_busy", busy, 1'b0);

        // 6: push arriving at the dwell terminal cycle while full.
        clear_log();
        send(8'hAA);
        tick();
        for (int i = 1; i <= 5; i++)
            send(8'h60 + 8'(i));
        tick(); tick();
        check("t6_full", fifo_count, 3'd4);
        send(8'h5A);
        check("t6_count", fifo_count, 3'd4);
        check("t6_ovf", overflow, 1'b0);
        wait_idle();
        exp_q = '{8'hAA, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h5A};
        verify_shown("t6");
        check("t6_ovf_end", overflow, 1'b0);
        check("t6_hold", disp_value, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
